// File: rtl/datapath_seq_ctrl_pkg.sv
// ============================================================================
// Module   : datapath_seq_ctrl_pkg
// Brief    : Shared encodings for the datapath sequencer (ops, states, WB select).
// Revision : 1.0
// ============================================================================
`default_nettype none

package datapath_seq_ctrl_pkg;

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [1:0] WB_SEL_F   = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MEM  = 2'b10,
        S_WB   = 2'b11
    } state_e;

endpackage

`default_nettype wire

// File: rtl/datapath_seq_ctrl.sv
// ============================================================================
// Module   : datapath_seq_ctrl
// Brief    : IDLE/EXEC/MEM/WB sequencer for the regfile + ALU + RAM datapath.
//            Define SEQ_OVF_TRAP_EN to suppress write-back of overflowed ALU
//            results and raise the sticky err flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module datapath_seq_ctrl
    import datapath_seq_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_alu_op,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              ZF,
    input  logic              OF,
    output logic [ADDR_W-1:0] rs,
    output logic [ADDR_W-1:0] rt,
    output logic [ADDR_W-1:0] rd,
    output logic [2:0]        ALU_OP,
    output logic              Write_Reg,
    output logic              Mem_Write,
    output logic [1:0]        wr_data_s,
    output logic              done,
    output logic              zf_q,
    output logic              of_q,
    output logic [CNT_W-1:0]  retired,
    output logic              err
);

    state_e             state_q, state_d;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   retired_q;
    logic               trap_w;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        Write_Reg = 1'b0;
        Mem_Write = 1'b0;
        wr_data_s = WB_SEL_F;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ALU:   state_d = S_WB;
                    OP_LOAD:  state_d = S_MEM;
                    OP_STORE: state_d = S_MEM;
                    OP_NOP: begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_MEM: begin
                if (op_q == OP_STORE) begin
                    Mem_Write = 1'b1;
                    done      = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                Write_Reg = ~trap_w;
                wr_data_s = (op_q == OP_LOAD) ? WB_SEL_MEM : WB_SEL_F;
                done      = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ALU;
            rs        <= '0;
            rt        <= '0;
            rd        <= '0;
            ALU_OP    <= '0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_valid && cmd_ready) begin
                op_q   <= cmd_op;
                rs     <= cmd_rs;
                rt     <= cmd_rt;
                rd     <= cmd_rd;
                ALU_OP <= cmd_alu_op;
            end
            // Flags are sampled once the datapath has settled on the EXEC operands.
            if (state_q == S_EXEC) begin
                zf_q <= ZF;
                of_q <= OF;
            end
            if (done) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired = retired_q;

`ifdef SEQ_OVF_TRAP_EN
    logic trap_q;
    logic err_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            trap_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (state_q == S_EXEC) begin
            trap_q <= (op_q == OP_ALU) && OF;
            if ((op_q == OP_ALU) && OF) err_q <= 1'b1;
        end
    end

    assign trap_w = trap_q;
    assign err    = err_q;
`else
    assign trap_w = 1'b0;
    assign err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_datapath_seq_ctrl.sv
// ============================================================================
// Module   : tb_datapath_seq_ctrl
// Brief    : Directed + randomized bench for datapath_seq_ctrl with a
//            per-command latency/enable reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_datapath_seq_ctrl;

    localparam int CNT_W  = 3;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              Reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [2:0]        cmd_alu_op;
    logic [ADDR_W-1:0] cmd_rs, cmd_rt, cmd_rd;
    logic              ZF, OF;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic [2:0]        ALU_OP;
    logic              Write_Reg, Mem_Write;
    logic [1:0]        wr_data_s;
    logic              done, zf_q, of_q;
    logic [CNT_W-1:0]  retired;
    logic              err;

    int checks   = 0;
    int failures = 0;
    int exp_retired = 0;
    logic exp_err = 1'b0;
    logic exp_zf = 1'b0;
    logic exp_of = 1'b0;

    always #5 clk = ~clk;

    datapath_seq_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_alu_op(cmd_alu_op),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .ZF(ZF), .OF(OF),
        .rs(rs), .rt(rt), .rd(rd), .ALU_OP(ALU_OP),
        .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .wr_data_s(wr_data_s),
        .done(done), .zf_q(zf_q), .of_q(of_q),
        .retired(retired), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One command, from the accept edge until the controller is back in IDLE.
    // The spec's latency rule: NOP 1, ALU 2, STORE 2, LOAD 3 cycles to done.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] aop,
                           input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                           input logic zf, input logic of, input bit hold_busy);
        int  lat;
        bit  is_alu, is_load, is_store, trap;
        is_alu   = (op == 2'b00);
        is_load  = (op == 2'b01);
        is_store = (op == 2'b10);
        lat = is_load ? 3 : ((op == 2'b11) ? 1 : 2);
`ifdef SEQ_OVF_TRAP_EN
        trap = is_alu && of;
`else
        trap = 1'b0;
`endif
        chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_alu_op = aop;
        cmd_rs = s; cmd_rt = t; cmd_rd = d;
        ZF = zf; OF = of;
        tick;
        for (int c = 1; c <= lat; c++) begin
            chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
            chk("rs", {27'd0, rs}, {27'd0, s});
            chk("rt", {27'd0, rt}, {27'd0, t});
            chk("rd", {27'd0, rd}, {27'd0, d});
            chk("alu_op", {29'd0, ALU_OP}, {29'd0, aop});
            chk("done", {31'd0, done}, {31'd0, (c == lat)});
            chk("write_reg", {31'd0, Write_Reg}, {31'd0, (c == lat) && (is_alu || is_load) && !trap});
            chk("mem_write", {31'd0, Mem_Write}, {31'd0, is_store && (c == 2)});
            chk("wr_data_s", {30'd0, wr_data_s}, ((c == lat) && is_load) ? 32'd1 : 32'd0);
            chk("retired_busy", {29'd0, retired}, 32'(exp_retired));
            chk("err", {31'd0, err}, {31'd0, exp_err});
            if (c == 1) begin
                exp_zf = zf; exp_of = of;
                if (trap) exp_err = 1'b1;
            end else begin
                chk("zf_latched", {31'd0, zf_q}, {31'd0, exp_zf});
                chk("of_latched", {31'd0, of_q}, {31'd0, exp_of});
                ZF = 1'($urandom); OF = 1'($urandom);
            end
            if (hold_busy) begin
                cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_alu_op = 3'($urandom);
                cmd_rs = 5'($urandom); cmd_rt = 5'($urandom); cmd_rd = 5'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            tick;
        end
        cmd_valid = 1'b0;
        exp_retired = (exp_retired + 1) % (1 << CNT_W);
        chk("ready_after_done", {31'd0, cmd_ready}, 32'd1);
        chk("done_idle", {31'd0, done}, 32'd0);
        chk("write_reg_idle", {31'd0, Write_Reg}, 32'd0);
        chk("retired", {29'd0, retired}, 32'(exp_retired));
        chk("zf_q", {31'd0, zf_q}, {31'd0, exp_zf});
        chk("of_q", {31'd0, of_q}, {31'd0, exp_of});
        chk("err_idle", {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_alu_op = '0;
        cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; ZF = 1'b0; OF = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_retired", {29'd0, retired}, 32'd0);
        chk("rst_write_reg", {31'd0, Write_Reg}, 32'd0);
        chk("rst_mem_write", {31'd0, Mem_Write}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_regs", {17'd0, rs, rt, rd}, 32'd0);
        chk("rst_flags", {29'd0, zf_q, of_q, err}, 32'd0);
        Reset = 1'b0;
        tick;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Directed: add, store, load, sub-equal, nop, overflowing add, busy hold.
        run_cmd(2'b00, 3'b010, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        run_cmd(2'b10, 3'b010, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        run_cmd(2'b01, 3'b010, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        run_cmd(2'b00, 3'b110, 5'd2, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0);
        run_cmd(2'b11, 3'b000, 5'd7, 5'd8, 5'd9, 1'b0, 1'b0, 1'b0);
        run_cmd(2'b00, 3'b010, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b0);
        run_cmd(2'b01, 3'b010, 5'd3, 5'd0, 5'd10, 1'b0, 1'b1, 1'b1);
        run_cmd(2'b10, 3'b010, 5'd4, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1);

        // Reset in the middle of an ALU write-back.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_alu_op = 3'b010;
        cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd3; ZF = 1'b1; OF = 1'b0;
        tick;
        cmd_valid = 1'b0;
        tick;
        chk("pre_rst_write_reg", {31'd0, Write_Reg}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("midwb_write_reg", {31'd0, Write_Reg}, 32'd0);
        chk("midwb_done", {31'd0, done}, 32'd0);
        chk("midwb_retired", {29'd0, retired}, 32'd0);
        chk("midwb_rd", {27'd0, rd}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        tick;
        exp_retired = 0; exp_err = 1'b0; exp_zf = 1'b0; exp_of = 1'b0;
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_retired", {29'd0, retired}, 32'd0);
        chk("post_rst_zf", {31'd0, zf_q}, 32'd0);
        chk("post_rst_err", {31'd0, err}, 32'd0);

        // Randomized commands with optional idle gaps; retired wraps several times.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick;
                chk("gap_ready", {31'd0, cmd_ready}, 32'd1);
                chk("gap_retired", {29'd0, retired}, 32'(exp_retired));
            end
            run_cmd(2'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
